// File: rtl/fp_align_shifter.sv
// Mantissa alignment stage of the FP adder: swaps operands and right-shifts the small mantissa with guard/round/sticky.
// Define FP_ALIGN_SINGLE_CYCLE_EN to do the whole shift in one barrel step at accept time.
module fp_align_shifter #(
    parameter int SHIFT_STEP = 4,
    parameter int MAN_W      = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [7:0]         exp_a,
    input  logic [7:0]         exp_b,
    input  logic [MAN_W-1:0]   man_a,
    input  logic [MAN_W-1:0]   man_b,
    input  logic               a_lt_b,
    input  logic               a_eq_b,
    input  logic               a_gt_b,
    input  logic [7:0]         abs_diff,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [7:0]         exp_big,
    output logic [MAN_W-1:0]   man_big,
    output logic [MAN_W+2:0]   man_small,
    output logic               swapped
);

    localparam int WW = MAN_W + 3;
    localparam int RW = $clog2(WW + 1);
    localparam logic [RW-1:0] STEP = RW'(SHIFT_STEP);
    localparam logic [RW-1:0] SAT  = RW'(WW);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state_q, state_d;
    logic [7:0]         exp_big_q, exp_big_d;
    logic [MAN_W-1:0]   man_big_q, man_big_d;
    logic [WW-1:0]      work_q, work_d;
    logic [RW-1:0]      rem_q, rem_d;
    logic               swapped_q, swapped_d;

    logic [MAN_W-1:0]   small_sel;
    logic [RW-1:0]      rem_load;
    logic [RW-1:0]      k;

    // The comparator's eq/gt flags are implied by lt and carry no extra information here.
    logic unused_flags;
    assign unused_flags = a_eq_b ^ a_gt_b;

    // Shift right by amt; bit0 becomes the OR of every bit at or below position amt, so sticky accumulates.
    function automatic logic [WW-1:0] align_shift(input logic [WW-1:0] w, input logic [RW-1:0] amt);
        logic [WW:0]   one;
        logic [WW:0]   mask;
        logic [RW:0]   amt1;
        logic [WW-1:0] r;
        one  = {{WW{1'b0}}, 1'b1};
        amt1 = {1'b0, amt} + {{RW{1'b0}}, 1'b1};
        mask = (one << amt1) - one;
        r    = w >> amt;
        r[0] = |(w & mask[WW-1:0]);
        return r;
    endfunction

    always_comb begin
        state_d   = state_q;
        exp_big_d = exp_big_q;
        man_big_d = man_big_q;
        work_d    = work_q;
        rem_d     = rem_q;
        swapped_d = swapped_q;
        small_sel = a_lt_b ? man_a : man_b;
        rem_load  = (abs_diff >= 8'(WW)) ? SAT : RW'(abs_diff);
        k         = (rem_q > STEP) ? STEP : rem_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    exp_big_d = a_lt_b ? exp_b : exp_a;
                    man_big_d = a_lt_b ? man_b : man_a;
                    swapped_d = a_lt_b;
`ifdef FP_ALIGN_SINGLE_CYCLE_EN
                    work_d    = align_shift({small_sel, 3'b000}, rem_load);
                    rem_d     = '0;
                    state_d   = DONE;
`else
                    work_d    = {small_sel, 3'b000};
                    rem_d     = rem_load;
                    state_d   = (rem_load == '0) ? DONE : SHIFT;
`endif
                end
            end
            SHIFT: begin
                work_d = align_shift(work_q, k);
                rem_d  = rem_q - k;
                if (rem_q == k) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            exp_big_q <= '0;
            man_big_q <= '0;
            work_q    <= '0;
            rem_q     <= '0;
            swapped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            exp_big_q <= exp_big_d;
            man_big_q <= man_big_d;
            work_q    <= work_d;
            rem_q     <= rem_d;
            swapped_q <= swapped_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign exp_big   = exp_big_q;
    assign man_big   = man_big_q;
    assign man_small = work_q;
    assign swapped   = swapped_q;

endmodule

// File: tb/tb_fp_align_shifter.sv
// Self-checking bench for fp_align_shifter: directed cases plus randomized bundles against an arithmetic reference model.
module tb_fp_align_shifter;

    localparam int STEP = 4;
    localparam int MW   = 24;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [7:0]      exp_a, exp_b;
    logic [MW-1:0]   man_a, man_b;
    logic            a_lt_b, a_eq_b, a_gt_b;
    logic [7:0]      abs_diff;
    logic            out_valid;
    logic            out_ready;
    logic [7:0]      exp_big;
    logic [MW-1:0]   man_big;
    logic [MW+2:0]   man_small;
    logic            swapped;

    int errors = 0;
    int checks = 0;

    fp_align_shifter #(.SHIFT_STEP(STEP), .MAN_W(MW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .exp_a(exp_a), .exp_b(exp_b), .man_a(man_a), .man_b(man_b),
        .a_lt_b(a_lt_b), .a_eq_b(a_eq_b), .a_gt_b(a_gt_b), .abs_diff(abs_diff),
        .out_valid(out_valid), .out_ready(out_ready),
        .exp_big(exp_big), .man_big(man_big), .man_small(man_small), .swapped(swapped)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: divide by 2^r, sticky set if any remainder bits were lost.
    function automatic logic [MW+2:0] ref_small(input logic [MW-1:0] m, input int unsigned d);
        longint unsigned full, pw, q, rest;
        int unsigned r;
        r    = (d > MW + 3) ? MW + 3 : d;
        full = longint'(m) * 8;
        pw   = 64'd1 << r;
        q    = full / pw;
        rest = full - q * pw;
        if (rest != 0) q = q | 64'd1;
        return q[MW+2:0];
    endfunction

    function automatic int ref_lat(input int unsigned d);
        int unsigned r;
        r = (d > MW + 3) ? MW + 3 : d;
`ifdef FP_ALIGN_SINGLE_CYCLE_EN
        return 1;
`else
        return 1 + int'((r + STEP - 1) / STEP);
`endif
    endfunction

    task automatic scramble();
        exp_a    = 8'($urandom);
        exp_b    = 8'($urandom);
        man_a    = MW'($urandom);
        man_b    = MW'($urandom);
        a_lt_b   = 1'($urandom);
        a_eq_b   = 1'($urandom);
        a_gt_b   = 1'($urandom);
        abs_diff = 8'($urandom);
    endtask

    task automatic run_op(input string tag, input logic [7:0] ea, input logic [7:0] eb,
                          input logic [MW-1:0] ma, input logic [MW-1:0] mb,
                          input logic lt, input logic eq, input logic gt,
                          input logic [7:0] diff, input int bp);
        logic [7:0]    e_exp;
        logic [MW-1:0] e_big;
        logic [MW+2:0] e_small;
        int            e_lat;
        int            n;
        e_exp   = lt ? eb : ea;
        e_big   = lt ? mb : ma;
        e_small = ref_small(lt ? ma : mb, diff);
        e_lat   = ref_lat(diff);

        @(negedge clk);
        chk({tag, ".in_ready_idle"}, 64'(in_ready), 64'd1);
        exp_a = ea; exp_b = eb; man_a = ma; man_b = mb;
        a_lt_b = lt; a_eq_b = eq; a_gt_b = gt; abs_diff = diff;
        in_valid = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        scramble();
        n = 1;
        while (!out_valid && n < 60) begin
            chk({tag, ".busy_in_ready"}, 64'(in_ready), 64'd0);
            @(negedge clk);
            n++;
        end
        chk({tag, ".latency"}, 64'(n), 64'(e_lat));
        chk({tag, ".exp_big"}, 64'(exp_big), 64'(e_exp));
        chk({tag, ".man_big"}, 64'(man_big), 64'(e_big));
        chk({tag, ".man_small"}, 64'(man_small), 64'(e_small));
        chk({tag, ".swapped"}, 64'(swapped), 64'(lt));
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            chk({tag, ".hold_valid"}, 64'(out_valid), 64'd1);
            chk({tag, ".hold_in_ready"}, 64'(in_ready), 64'd0);
            chk({tag, ".hold_small"}, 64'(man_small), 64'(e_small));
            chk({tag, ".hold_big"}, 64'(man_big), 64'(e_big));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, ".release_valid"}, 64'(out_valid), 64'd0);
        chk({tag, ".release_in_ready"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        scramble();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset.out_valid", 64'(out_valid), 64'd0);
        chk("reset.in_ready", 64'(in_ready), 64'd1);
        chk("reset.exp_big", 64'(exp_big), 64'd0);
        chk("reset.man_big", 64'(man_big), 64'd0);
        chk("reset.man_small", 64'(man_small), 64'd0);
        chk("reset.swapped", 64'(swapped), 64'd0);
        rst = 1'b0;

        run_op("basic_gt", 8'h85, 8'h83, 24'h800000, 24'hC00000, 1'b0, 1'b0, 1'b1, 8'd2, 0);
        chk("basic_gt.lit_small", 64'(man_small), 64'h1800000);
        chk("basic_gt.lit_exp", 64'(exp_big), 64'h85);

        run_op("swap_lt", 8'h8F, 8'h90, 24'h900000, 24'hA00000, 1'b1, 1'b0, 1'b0, 8'd1, 0);
        chk("swap_lt.lit_small", 64'(man_small), 64'h2400000);
        chk("swap_lt.lit_big", 64'(man_big), 64'hA00000);

        run_op("sticky", 8'h40, 8'h3C, 24'hFFFFFF, 24'h800001, 1'b0, 1'b0, 1'b1, 8'd4, 0);
        chk("sticky.lit_small", 64'(man_small), 64'h0400001);

        run_op("saturate", 8'h60, 8'h42, 24'h800000, 24'h800001, 1'b0, 1'b0, 1'b1, 8'd30, 0);
        chk("saturate.lit_small", 64'(man_small), 64'h0000001);

        run_op("sat_exact27", 8'h60, 8'h45, 24'hABCDEF, 24'h000001, 1'b0, 1'b0, 1'b1, 8'd27, 1);
        run_op("diff26", 8'h60, 8'h46, 24'hABCDEF, 24'hFFFFFF, 1'b0, 1'b0, 1'b1, 8'd26, 0);
        run_op("diff255", 8'h10, 8'hFF, 24'h123456, 24'h800000, 1'b1, 1'b0, 1'b0, 8'd255, 0);

        run_op("eq_bp", 8'h7F, 8'h7F, 24'hC00000, 24'hB12345, 1'b0, 1'b1, 1'b0, 8'd0, 3);
        chk("eq_bp.lit_small", 64'(man_small), 64'({24'hB12345, 3'b000}));

        // Abort a bundle with reset during its second SHIFT cycle.
        @(negedge clk);
        exp_a = 8'h90; exp_b = 8'h7C; man_a = 24'hFFFFFF; man_b = 24'hFFFFFF;
        a_lt_b = 1'b0; a_eq_b = 1'b0; a_gt_b = 1'b1; abs_diff = 8'd20;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid.out_valid", 64'(out_valid), 64'd0);
        chk("rst_mid.in_ready", 64'(in_ready), 64'd1);
        chk("rst_mid.man_small", 64'(man_small), 64'd0);
        chk("rst_mid.man_big", 64'(man_big), 64'd0);
        chk("rst_mid.exp_big", 64'(exp_big), 64'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("rst_mid.no_output", 64'(out_valid), 64'd0);
        end

        for (int i = 0; i < 40; i++) begin
            logic       lt;
            logic [7:0] d;
            lt = 1'($urandom);
            d  = (i % 5 == 0) ? 8'($urandom) : 8'($urandom_range(0, 30));
            run_op("rand", 8'($urandom), 8'($urandom), MW'($urandom), MW'($urandom),
                   lt, 1'b0, ~lt, d, int'($urandom_range(0, 2)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
